gen3_framing_scheduler: RTL and testbench

- Transmit-side byte scheduler for the Gen3 (128b/130b) MAC path.
- Arbitrates between one TLP requester and one DLLP requester and frames each packet with an STP or SDP token.
- Fills gaps with IDL bytes and marks 16-byte block boundaries with the data sync header.
- Emits one byte per accepted cycle in the exact format the Gen3 receive-side byte checker decodes.

---
 rtl/gen3_framing_scheduler_pkg.sv | 49 ++++
 rtl/gen3_framing_scheduler_rr_arb2.sv | 44 ++++
 rtl/gen3_framing_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_gen3_framing_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen3_framing_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// gen3_framing_pkg
// Shared definitions for the Gen3 (128b/130b) transmit framing scheduler and
// the matching receive-side byte checker: framing token bytes, the data block
// sync header, FSM state encoding, round-robin owner encoding and the STP
// token byte builder.
// Optional feature macro: GEN3_EDB_NULLIFY_EN (adds the EDB_TOK state).
// -----------------------------------------------------------------------------
package gen3_framing_pkg;

  localparam logic [3:0] STP_NIB   = 4'hF;
  localparam logic [7:0] SDP_B0    = 8'hF0;
  localparam logic [7:0] SDP_B1    = 8'hAC;
  localparam logic [7:0] EDB_B     = 8'hC0;
  localparam logic [7:0] IDL_B     = 8'h00;
  localparam logic [1:0] SYNC_DATA = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    STP_TOK,
    TLP_BODY,
    SDP_TOK,
    DLLP_BODY
`ifdef GEN3_EDB_NULLIFY_EN
    ,
    EDB_TOK
`endif
  } fsm_state_t;

  typedef enum logic {
    RR_TLP,
    RR_DLLP
  } rr_owner_t;

  // Byte idx (0..3) of the 4-byte STP token for a given length and sequence.
  function automatic logic [7:0] stp_byte(input logic [10:0] len,
                                          input logic [11:0] seq,
                                          input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {len[3:0], STP_NIB};
      2'd1:    b = {1'b0, len[10:4]};
      2'd2:    b = {4'h0, seq[11:8]};
      default: b = seq[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gen3_framing_scheduler_rr_arb2.sv
// -----------------------------------------------------------------------------
// gen3_rr_arb2
// Two-requester round-robin arbiter. Requester A is the TLP source, B the
// DLLP source. Grants are only issued while en is high (aligned idle slot);
// the owner memory moves only when the granted byte is actually transferred.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              arbitration slot open
//   req_a, req_b    requests
//   upd             granted byte transferred this cycle
//   gnt_a, gnt_b    combinational one-hot grant
// -----------------------------------------------------------------------------
module gen3_rr_arb2
  import gen3_framing_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  input  logic upd,
  output logic gnt_a,
  output logic gnt_b
);

  rr_owner_t rr_last;

  always_comb begin
    gnt_a = en && req_a && (!req_b || (rr_last == RR_DLLP));
    gnt_b = en && req_b && (!req_a || (rr_last == RR_TLP));
  end

  // Reset to DLLP so that the TLP side wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= RR_DLLP;
    end else if (upd && gnt_a) begin
      rr_last <= RR_TLP;
    end else if (upd && gnt_b) begin
      rr_last <= RR_DLLP;
    end
  end

endmodule

// File: rtl/gen3_framing_scheduler.sv
// -----------------------------------------------------------------------------
// gen3_framing_scheduler
// Gen3 transmit byte scheduler: arbitrates one TLP and one DLLP requester,
// frames packets with STP / SDP tokens, fills gaps with IDL and flags the
// first byte of every 16-byte block (sync header 2'b01).
// Optional feature macro: GEN3_EDB_NULLIFY_EN -- tlp_abort, or a 4-cycle
// body underrun, ends the TLP with an EDB token (C0 x4).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   tlp_req/tlp_len_dw/tlp_seq    TLP request, length in DW (incl. token), seq
//   tlp_gnt                       pulse on STP byte0 transfer
//   tlp_data/_valid/_ready        TLP body byte stream
//   tlp_abort                     nullify current TLP (EDB build only)
//   dllp_req/dllp_data            DLLP request and 6 body bytes (byte0 LSB)
//   dllp_gnt                      pulse on SDP byte0 transfer
//   out_data/_valid/_ready        framed byte stream
//   out_sync_hdr/out_block_start  block sync header, byte 0 of block flag
//   len_err                       pulse when a too-short TLP is rejected
// -----------------------------------------------------------------------------
module gen3_framing_scheduler
  import gen3_framing_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int DLLP_BYTES  = 6,
  parameter int MIN_TLP_DW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tlp_req,
  input  logic [10:0] tlp_len_dw,
  input  logic [11:0] tlp_seq,
  output logic        tlp_gnt,
  input  logic [7:0]  tlp_data,
  input  logic        tlp_data_valid,
  output logic        tlp_data_ready,
  input  logic        tlp_abort,
  input  logic        dllp_req,
  input  logic [47:0] dllp_data,
  output logic        dllp_gnt,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_sync_hdr,
  output logic        out_block_start,
  output logic        len_err
);

  localparam int          BW        = $clog2(BLOCK_BYTES);
  localparam logic [12:0] DLLP_LAST = 13'(DLLP_BYTES - 1);
  localparam logic [10:0] MIN_LEN   = 11'(MIN_TLP_DW);

  fsm_state_t      state, state_nxt;
  logic [BW-1:0]   blk_idx;
  logic [12:0]     byte_cnt, cnt_nxt;
  logic [12:0]     limit;
  logic            len_rej, rej_nxt;
  logic [10:0]     len_q;
  logic [11:0]     seq_q;
  logic [47:0]     dllp_q;
  logic            xfer, ld_tlp, ld_dllp;
  logic            aligned, len_bad, arb_en, gnt_t, gnt_d;

`ifdef GEN3_EDB_NULLIFY_EN
  logic [1:0]      urun, urun_nxt;
`else
  logic            unused_abort;
  assign unused_abort = tlp_abort;
`endif

  assign aligned = (blk_idx[1:0] == 2'b00);
  assign len_bad = (tlp_len_dw < MIN_LEN);
  assign limit   = {len_q, 2'b00} - 13'd4;
  assign arb_en  = !rst && (state == IDLE) && aligned;

  assign out_sync_hdr    = SYNC_DATA;
  assign out_block_start = !rst && (blk_idx == '0);

  gen3_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req_a (tlp_req && !len_bad),
    .req_b (dllp_req),
    .upd   (xfer),
    .gnt_a (gnt_t),
    .gnt_b (gnt_d)
  );

  // Control state: advances only on a transfer (or an EDB abort).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      blk_idx  <= '0;
      byte_cnt <= '0;
      len_rej  <= 1'b0;
`ifdef GEN3_EDB_NULLIFY_EN
      urun     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      byte_cnt <= cnt_nxt;
      len_rej  <= rej_nxt;
      if (xfer) begin
        blk_idx <= blk_idx + BW'(1);
      end
`ifdef GEN3_EDB_NULLIFY_EN
      urun     <= urun_nxt;
`endif
    end
  end

  // Packet fields captured at grant.
  always_ff @(posedge clk) begin
    if (ld_tlp) begin
      len_q <= tlp_len_dw;
      seq_q <= tlp_seq;
    end
    if (ld_dllp) begin
      dllp_q <= dllp_data;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = byte_cnt;
    out_valid      = 1'b0;
    out_data       = IDL_B;
    tlp_data_ready = 1'b0;
    tlp_gnt        = 1'b0;
    dllp_gnt       = 1'b0;
    len_err        = 1'b0;
    ld_tlp         = 1'b0;
    ld_dllp        = 1'b0;
    xfer           = 1'b0;
    rej_nxt        = len_rej && tlp_req;
`ifdef GEN3_EDB_NULLIFY_EN
    urun_nxt       = '0;
`endif
    if (!rst) begin
      case (state)
        IDLE: begin
          out_valid = 1'b1;
          // Token byte0 goes out in the grant cycle itself.
          if (gnt_t) begin
            out_data = stp_byte(tlp_len_dw, tlp_seq, 2'd0);
          end else if (gnt_d) begin
            out_data = SDP_B0;
          end
          xfer = out_ready;
          if (xfer) begin
            if (gnt_t) begin
              tlp_gnt   = 1'b1;
              ld_tlp    = 1'b1;
              state_nxt = STP_TOK;
              cnt_nxt   = 13'd1;
            end else if (gnt_d) begin
              dllp_gnt  = 1'b1;
              ld_dllp   = 1'b1;
              state_nxt = SDP_TOK;
            end
            // One pulse per request: len_rej holds until tlp_req drops.
            if (aligned && tlp_req && len_bad && !len_rej) begin
              len_err = 1'b1;
              rej_nxt = 1'b1;
            end
          end
        end
        STP_TOK: begin
          out_valid = 1'b1;
          out_data  = stp_byte(len_q, seq_q, byte_cnt[1:0]);
          xfer      = out_ready;
          if (xfer) begin
            if (byte_cnt[1:0] == 2'd3) begin
              state_nxt = TLP_BODY;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = byte_cnt + 13'd1;
            end
          end
        end
        TLP_BODY: begin
`ifdef GEN3_EDB_NULLIFY_EN
          out_valid = tlp_data_valid && !tlp_abort;
`else
          out_valid = tlp_data_valid;
`endif
          out_data       = tlp_data;
          xfer           = out_valid && out_ready;
          tlp_data_ready = xfer;
          if (xfer) begin
            if (byte_cnt + 13'd1 == limit) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = byte_cnt + 13'd1;
            end
          end
`ifdef GEN3_EDB_NULLIFY_EN
          if (!tlp_data_valid) begin
            urun_nxt = urun + 2'd1;
          end
          // Abort or the 4th consecutive underrun cycle nullifies the TLP.
          if (tlp_abort || (!tlp_data_valid && (urun == 2'd3))) begin
            state_nxt = EDB_TOK;
            cnt_nxt   = '0;
          end
`endif
        end
        SDP_TOK: begin
          out_valid = 1'b1;
          out_data  = SDP_B1;
          xfer      = out_ready;
          if (xfer) begin
            state_nxt = DLLP_BODY;
            cnt_nxt   = '0;
          end
        end
        DLLP_BODY: begin
          out_valid = 1'b1;
          out_data  = dllp_q[{byte_cnt[2:0], 3'b000} +: 8];
          xfer      = out_ready;
          if (xfer) begin
            if (byte_cnt == DLLP_LAST) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = byte_cnt + 13'd1;
            end
          end
        end
`ifdef GEN3_EDB_NULLIFY_EN
        EDB_TOK: begin
          out_valid = 1'b1;
          out_data  = EDB_B;
          xfer      = out_ready;
          if (xfer) begin
            if (byte_cnt[1:0] == 2'd3) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = byte_cnt + 13'd1;
            end
          end
        end
`endif
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gen3_framing_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gen3_framing_scheduler
// Directed bench for gen3_framing_scheduler: per-cycle vector table plus
// sequences for length rejection, random back-pressure and TLP nullify.
// Honours GEN3_EDB_NULLIFY_EN for the expected abort behaviour.
// -----------------------------------------------------------------------------
module tb_gen3_framing_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        tlp_req;
  logic [10:0] tlp_len_dw;
  logic [11:0] tlp_seq;
  logic        tlp_gnt;
  logic [7:0]  tlp_data;
  logic        tlp_data_valid;
  logic        tlp_data_ready;
  logic        tlp_abort;
  logic        dllp_req;
  logic [47:0] dllp_data;
  logic        dllp_gnt;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sync_hdr;
  logic        out_block_start;
  logic        len_err;

  always #5 clk = ~clk;

  gen3_framing_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .tlp_req         (tlp_req),
    .tlp_len_dw      (tlp_len_dw),
    .tlp_seq         (tlp_seq),
    .tlp_gnt         (tlp_gnt),
    .tlp_data        (tlp_data),
    .tlp_data_valid  (tlp_data_valid),
    .tlp_data_ready  (tlp_data_ready),
    .tlp_abort       (tlp_abort),
    .dllp_req        (dllp_req),
    .dllp_data       (dllp_data),
    .dllp_gnt        (dllp_gnt),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sync_hdr    (out_sync_hdr),
    .out_block_start (out_block_start),
    .len_err         (len_err)
  );

  typedef struct {
    logic        rst;
    logic        treq;
    logic [10:0] len;
    logic [11:0] seq;
    logic [7:0]  tdata;
    logic        tvld;
    logic        dreq;
    logic [47:0] ddata;
    logic        evld;
    logic [7:0]  edata;
    logic        ebs;
    logic        etg;
    logic        edg;
    logic        etr;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   hold_err = 0;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_stream(input string name, input logic [7:0] got[$],
                            input logic [7:0] exp[$], input bit timeout);
    bit ok;
    ok = !timeout && (got.size() == exp.size());
    for (int i = 0; ok && i < exp.size(); i++)
      if (got[i] !== exp[i]) begin
        ok = 1'b0;
        $display("FAIL %s: byte %0d got %h expected %h", name, i, got[i], exp[i]);
      end
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: stream size got %0d expected %0d timeout %0d", name, got.size(), exp.size(), timeout);
  endtask

  task automatic add(input logic r, input logic tq, input logic [10:0] ln,
                     input logic [11:0] sq, input logic [7:0] td, input logic tv,
                     input logic dq, input logic [47:0] dd, input logic ev,
                     input logic [7:0] ed, input logic eb, input logic etg,
                     input logic edg, input logic etr);
    vec_t v;
    v.rst = r; v.treq = tq; v.len = ln; v.seq = sq; v.tdata = td; v.tvld = tv;
    v.dreq = dq; v.ddata = dd; v.evld = ev; v.edata = ed; v.ebs = eb;
    v.etg = etg; v.edg = edg; v.etr = etr;
    vecs.push_back(v);
  endtask

  // Runs one TLP (bodies 11,12,...) to completion and gathers transferred bytes
  // from its STP byte0 onward. abort_after<0 never aborts.
  task automatic run_tlp(input logic [10:0] len, input logic [11:0] seq,
                         input int abort_after, input bit rnd, input int nbytes,
                         output logic [7:0] got[$], output bit timeout);
    int k = 0;
    int cyc = 0;
    bit granted = 1'b0;
    bit prev_stall = 1'b0;
    logic [8:0] prev = '0;
    got = {};
    timeout = 1'b0;
    while (got.size() < nbytes) begin
      tlp_req        = !granted;
      tlp_len_dw     = len;
      tlp_seq        = seq;
      tlp_data       = 8'(8'h11 + k);
      tlp_data_valid = 1'b1;
      tlp_abort      = (abort_after >= 0) && (k >= abort_after);
      out_ready      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (prev_stall && ({out_valid, out_data} !== prev)) hold_err++;
      prev_stall = !out_ready;
      prev       = {out_valid, out_data};
      if (out_valid && out_ready && (granted || tlp_gnt)) got.push_back(out_data);
      if (tlp_gnt) granted = 1'b1;
      if (tlp_data_ready) k++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 400) begin
        timeout = 1'b1;
        break;
      end
    end
    tlp_req = 1'b0; tlp_abort = 1'b0; tlp_data_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    logic [47:0] d1;
    logic [47:0] d2;
    logic [10:0] l2;
    logic [7:0]  got[$];
    logic [7:0]  exp[$];
    bit          to;
    int          pulses, gnts, bad;

    rst = 1'b1; tlp_req = 1'b0; tlp_len_dw = '0; tlp_seq = '0; tlp_data = '0;
    tlp_data_valid = 1'b0; tlp_abort = 1'b0; dllp_req = 1'b0; dllp_data = '0;
    out_ready = 1'b1;

    d1 = 48'h665544332211;
    d2 = 48'hF6F5F4F3F2F1;
    l2 = 11'd2;

    // Reset, then 32 idle bytes.
    add(I,O,'0,'0,'0,O,O,'0, O,8'h00,O,O,O,O);
    add(I,O,'0,'0,'0,O,O,'0, O,8'h00,O,O,O,O);
    for (int i = 0; i < 32; i++)
      add(O,O,'0,'0,'0,O,O,'0, I,8'h00,(i % 16 == 0),O,O,O);

    // TLP len 3, seq 123, bodies 11..18 (block idx 0..11), then IDL.
    add(O,I,11'd3,12'h123,'0,O,O,'0, I,8'h3F,I,I,O,O);
    add(O,O,11'd3,12'h123,'0,O,O,'0, I,8'h00,O,O,O,O);
    add(O,O,11'd3,12'h123,'0,O,O,'0, I,8'h01,O,O,O,O);
    add(O,O,11'd3,12'h123,'0,O,O,'0, I,8'h23,O,O,O,O);
    for (int i = 0; i < 8; i++)
      add(O,O,11'd3,12'h123,8'(8'h11 + i),I,O,'0, I,8'(8'h11 + i),O,O,O,I);
    for (int i = 12; i < 18; i++)
      add(O,O,'0,'0,'0,O,O,'0, I,8'h00,(i == 16),O,O,O);

    // DLLP requested at block idx 2: IDL at 2,3, SDP from idx 4.
    add(O,O,'0,'0,'0,O,I,d1, I,8'h00,O,O,O,O);
    add(O,O,'0,'0,'0,O,I,d1, I,8'h00,O,O,O,O);
    add(O,O,'0,'0,'0,O,I,d1, I,8'hF0,O,O,I,O);
    add(O,O,'0,'0,'0,O,O,'0, I,8'hAC,O,O,O,O);
    for (int i = 0; i < 6; i++)
      add(O,O,'0,'0,'0,O,O,'0, I,8'(8'h11 * (i + 1)),O,O,O,O);
    add(O,O,'0,'0,'0,O,O,'0, I,8'h00,O,O,O,O);

    // Both requesting from reset: TLP, then DLLP (round robin), then TLP.
    add(I,I,l2,12'hABC,'0,O,I,d2, O,8'h00,O,O,O,O);
    add(O,I,l2,12'hABC,'0,O,I,d2, I,8'h2F,I,I,O,O);
    add(O,O,l2,12'hABC,'0,O,I,d2, I,8'h00,O,O,O,O);
    add(O,I,l2,12'h456,'0,O,I,d2, I,8'h0A,O,O,O,O);
    add(O,I,l2,12'h456,'0,O,I,d2, I,8'hBC,O,O,O,O);
    for (int i = 0; i < 4; i++)
      add(O,I,l2,12'h456,8'(i + 1),I,I,d2, I,8'(i + 1),O,O,O,I);
    add(O,I,l2,12'h456,'0,O,I,d2, I,8'hF0,O,O,I,O);
    add(O,I,l2,12'h456,'0,O,O,'0, I,8'hAC,O,O,O,O);
    for (int i = 0; i < 6; i++)
      add(O,I,l2,12'h456,'0,O,O,'0, I,8'(8'hF1 + i),O,O,O,O);
    add(O,I,l2,12'h456,'0,O,O,'0, I,8'h2F,I,I,O,O);
    add(O,O,l2,12'h456,'0,O,O,'0, I,8'h00,O,O,O,O);
    add(O,O,l2,12'h456,'0,O,O,'0, I,8'h04,O,O,O,O);
    add(O,O,l2,12'h456,'0,O,O,'0, I,8'h56,O,O,O,O);
    for (int i = 0; i < 4; i++)
      add(O,O,l2,12'h456,8'(8'hA1 + i),I,O,'0, I,8'(8'hA1 + i),O,O,O,I);
    add(O,O,'0,'0,'0,O,O,'0, I,8'h00,O,O,O,O);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; tlp_req = vecs[i].treq; tlp_len_dw = vecs[i].len;
      tlp_seq = vecs[i].seq; tlp_data = vecs[i].tdata; tlp_data_valid = vecs[i].tvld;
      dllp_req = vecs[i].dreq; dllp_data = vecs[i].ddata; out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          64'({out_valid, out_data, out_block_start, out_sync_hdr,
               tlp_gnt, dllp_gnt, tlp_data_ready, len_err}),
          64'({vecs[i].evld, vecs[i].edata, vecs[i].ebs, 2'b01,
               vecs[i].etg, vecs[i].edg, vecs[i].etr, 1'b0}));
      @(posedge clk); #1;
    end
    rst = 1'b0; tlp_req = 1'b0; dllp_req = 1'b0; tlp_data_valid = 1'b0;

    // Too-short TLP held for 8 cycles (block idx 9..0): exactly one len_err.
    tlp_req = 1'b1; tlp_len_dw = 11'd1; pulses = 0; gnts = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pulses += int'(len_err);
      gnts   += int'(tlp_gnt);
      if (!(out_valid && out_data == 8'h00)) bad++;
      @(posedge clk); #1;
    end
    tlp_req = 1'b0;
    @(posedge clk); #1;
    chk("len_err_pulses", 64'(pulses), 64'd1);
    chk("len_err_no_gnt", 64'(gnts), 64'd0);
    chk("len_err_idle_stream", 64'(bad), 64'd0);

    // Random back-pressure must not change the byte sequence.
    exp = '{8'h3F, 8'h00, 8'h01, 8'h23, 8'h11, 8'h12, 8'h13, 8'h14,
            8'h15, 8'h16, 8'h17, 8'h18, 8'h00};
    run_tlp(11'd3, 12'h123, -1, 1'b1, 13, got, to);
    chk_stream("backpressure_stream", got, exp, to);
    chk("backpressure_hold", 64'(hold_err), 64'd0);

    // Abort after two body bytes.
`ifdef GEN3_EDB_NULLIFY_EN
    exp = '{8'h3F, 8'h00, 8'h01, 8'h23, 8'h11, 8'h12,
            8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h00};
`else
    exp = '{8'h3F, 8'h00, 8'h01, 8'h23, 8'h11, 8'h12, 8'h13, 8'h14,
            8'h15, 8'h16, 8'h17, 8'h18, 8'h00};
`endif
    run_tlp(11'd3, 12'h123, 2, 1'b0, exp.size(), got, to);
    chk_stream("abort_stream", got, exp, to);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
